// File: rtl/qdr_app_responder.sv
// qdr_app_responder: behavioural QDR app-side responder with calibration
// delay, single-port-per-direction storage and a fixed-latency read pipe.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   init_calib_complete      high once the calibration delay has elapsed
//   user_app_wr_cmd/addr/data  write one word per cycle
//   user_app_rd_cmd/addr     read one word per cycle
//   user_app_rd_data/valid   read response, RD_LATENCY cycles later
//   addr_err                 sticky: an out-of-range command was dropped
//   wr_count, rd_count       accepted command counters (wrapping)
module qdr_app_responder #(
    parameter int QDR_DATA_WIDTH   = 36,
    parameter int QDR_BURST_LENGTH = 4,
    parameter int QDR_ADDR_WIDTH   = 19,
    parameter int MEM_DEPTH_LOG2   = 10,
    parameter int RD_LATENCY       = 8,
    parameter int CALIB_CYCLES     = 64
) (
    input  logic                                       clk,
    input  logic                                       rst,
    output logic                                       init_calib_complete,
    input  logic                                       user_app_wr_cmd,
    input  logic [QDR_ADDR_WIDTH-1:0]                  user_app_wr_addr,
    input  logic [QDR_DATA_WIDTH*QDR_BURST_LENGTH-1:0] user_app_wr_data,
    input  logic                                       user_app_rd_cmd,
    input  logic [QDR_ADDR_WIDTH-1:0]                  user_app_rd_addr,
    output logic [QDR_DATA_WIDTH*QDR_BURST_LENGTH-1:0] user_app_rd_data,
    output logic                                       user_app_rd_valid,
    output logic                                       addr_err,
    output logic [31:0]                                wr_count,
    output logic [31:0]                                rd_count
);

    localparam int W     = QDR_DATA_WIDTH * QDR_BURST_LENGTH;
    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int CW    = $clog2(CALIB_CYCLES + 1);

    logic [W-1:0]          mem_q [DEPTH];

    logic [CW-1:0]         cal_cnt_q, cal_cnt_d;
    logic                  cal_done_q, cal_done_d;
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [W-1:0]          dat_q [RD_LATENCY];
    logic [W-1:0]          dat_d [RD_LATENCY];
    logic                  err_q, err_d;
    logic [31:0]           wr_cnt_q, wr_cnt_d;
    logic [31:0]           rd_cnt_q, rd_cnt_d;

    logic                      wr_in_rng, rd_in_rng;
    logic                      wr_ok, rd_ok;
    logic [MEM_DEPTH_LOG2-1:0] wr_idx, rd_idx;

    assign wr_in_rng = (user_app_wr_addr >> MEM_DEPTH_LOG2) == '0;
    assign rd_in_rng = (user_app_rd_addr >> MEM_DEPTH_LOG2) == '0;
    assign wr_idx    = user_app_wr_addr[MEM_DEPTH_LOG2-1:0];
    assign rd_idx    = user_app_rd_addr[MEM_DEPTH_LOG2-1:0];
    assign wr_ok     = cal_done_q & user_app_wr_cmd & wr_in_rng;
    assign rd_ok     = cal_done_q & user_app_rd_cmd & rd_in_rng;

    always_comb begin
        cal_cnt_d = cal_cnt_q;
        cal_done_d = cal_done_q;
        if (!cal_done_q) begin
            cal_cnt_d = cal_cnt_q + 1'b1;
            if (cal_cnt_q == CW'(CALIB_CYCLES - 1)) begin
                cal_done_d = 1'b1;
            end
        end

        err_d = err_q;
        if (cal_done_q) begin
            if ((user_app_wr_cmd && !wr_in_rng) ||
                (user_app_rd_cmd && !rd_in_rng)) begin
                err_d = 1'b1;
            end
        end

        wr_cnt_d = wr_cnt_q + {31'd0, wr_ok};
        rd_cnt_d = rd_cnt_q + {31'd0, rd_ok};

        // Storage is read here, before the same-edge write lands, which
        // gives read-before-write for a same-cycle hit. Data stages carry
        // zero whenever they are invalid so the output needs no masking.
        vld_d[0] = rd_ok;
        dat_d[0] = rd_ok ? mem_q[rd_idx] : '0;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_idx] <= user_app_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cal_cnt_q <= '0;
            cal_done_q <= 1'b0;
            vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
            err_q <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            cal_cnt_q <= cal_cnt_d;
            cal_done_q <= cal_done_d;
            vld_q <= vld_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
            err_q <= err_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign init_calib_complete = cal_done_q;
    assign user_app_rd_valid   = vld_q[RD_LATENCY-1];
    assign user_app_rd_data    = dat_q[RD_LATENCY-1];
    assign addr_err            = err_q;
    assign wr_count            = wr_cnt_q;
    assign rd_count            = rd_cnt_q;

endmodule

// File: tb/tb_qdr_app_responder.sv
// tb_qdr_app_responder: scoreboard bench for qdr_app_responder with a
// queue/array reference model and randomized traffic.
module tb_qdr_app_responder;

    localparam int W    = 144;
    localparam int AW   = 19;
    localparam int ML   = 10;
    localparam int DEP  = 1 << ML;
    localparam int LAT  = 8;
    localparam int CAL  = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_calib_complete;
    logic          wr_cmd = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic          rd_cmd = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          addr_err;
    logic [31:0]   wr_count;
    logic [31:0]   rd_count;

    qdr_app_responder dut (
        .clk                 (clk),
        .rst                 (rst),
        .init_calib_complete (init_calib_complete),
        .user_app_wr_cmd     (wr_cmd),
        .user_app_wr_addr    (wr_addr),
        .user_app_wr_data    (wr_data),
        .user_app_rd_cmd     (rd_cmd),
        .user_app_rd_addr    (rd_addr),
        .user_app_rd_data    (rd_data),
        .user_app_rd_valid   (rd_valid),
        .addr_err            (addr_err),
        .wr_count            (wr_count),
        .rd_count            (rd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [W-1:0] d;
    } exp_t;

    exp_t         sb[$];
    int unsigned  cyc = 0;
    int           tests = 0;
    int           failed = 0;
    bit           mon_en = 0;

    logic [W-1:0] mdl_mem [DEP];
    bit           wrtn [DEP];
    int           cal_cnt = 0;
    logic [31:0]  exp_wr = 0;
    logic [31:0]  exp_rd = 0;
    bit           exp_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    // Monitor: compares every presented response against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("missed_rd_valid", W'(sb[0].cyc), W'(cyc));
                void'(sb.pop_front());
            end
            if (rd_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_rd_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rd_data", rd_data, e.d);
                    check("rd_latency_cycle", W'(cyc), W'(e.cyc));
                end
            end else begin
                check("rd_valid_known", W'(rd_valid), 0);
                check("rd_data_idle_zero", rd_data, 0);
            end
        end
    end

    task automatic do_cycle(input bit wr, input logic [AW-1:0] wa,
                            input logic [W-1:0] wd, input bit rd,
                            input logic [AW-1:0] ra);
        bit cal;
        exp_t e;
        cal = (cal_cnt >= CAL);
        if (rd && cal) begin
            if (ra < DEP) begin
                e.cyc = cyc + LAT;
                e.d = mdl_mem[ra[ML-1:0]];
                sb.push_back(e);
                exp_rd++;
            end else begin
                exp_err = 1;
            end
        end
        if (wr && cal) begin
            if (wa < DEP) begin
                mdl_mem[wa[ML-1:0]] = wd;
                wrtn[wa[ML-1:0]] = 1;
                exp_wr++;
            end else begin
                exp_err = 1;
            end
        end
        wr_cmd = wr;
        wr_addr = wa;
        wr_data = wd;
        rd_cmd = rd;
        rd_addr = ra;
        @(posedge clk);
        #1;
        wr_cmd = 0;
        rd_cmd = 0;
        if (cal_cnt < CAL) cal_cnt++;
        check("init_calib_complete", W'(init_calib_complete),
              W'(cal_cnt >= CAL));
        check("wr_count", W'(wr_count), W'(exp_wr));
        check("rd_count", W'(rd_count), W'(exp_rd));
        check("addr_err", W'(addr_err), W'(exp_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, '0, '0, 0, '0);
    endtask

    task automatic do_reset();
        wr_cmd = 0;
        rd_cmd = 0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        sb.delete();
        cal_cnt = 0;
        exp_wr = 0;
        exp_rd = 0;
        exp_err = 0;
        mon_en = 1;
        check("rst_calib", W'(init_calib_complete), 0);
        check("rst_rd_valid", W'(rd_valid), 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_addr_err", W'(addr_err), 0);
        check("rst_wr_count", W'(wr_count), 0);
        check("rst_rd_count", W'(rd_count), 0);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [W-1:0]  keep0;
        for (int i = 0; i < DEP; i++) wrtn[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Commands during calibration are ignored.
        for (int i = 0; i < CAL + 6; i++) begin
            do_cycle(i == 10, AW'(3), rnd_data(), i == 20, AW'(3));
        end

        // Single write then read of address 5.
        do_cycle(1, AW'(5), 144'h123456789ABCDEF0123456789ABCDEF012,
                 0, '0);
        do_cycle(0, '0, '0, 1, AW'(5));
        idle(LAT + 2);

        // Streaming writes then back-to-back reads.
        for (int i = 0; i < 16; i++) do_cycle(1, AW'(i), W'(i), 0, '0);
        for (int i = 0; i < 16; i++) do_cycle(0, '0, '0, 1, AW'(i));
        idle(LAT + 2);

        // Same-cycle read and write to one address.
        do_cycle(1, AW'(7), W'(8'hAA), 0, '0);
        do_cycle(1, AW'(7), W'(8'hBB), 1, AW'(7));
        do_cycle(0, '0, '0, 1, AW'(7));
        idle(LAT + 2);

        // Out-of-range write must not alias onto address 0.
        keep0 = rnd_data();
        do_cycle(1, AW'(0), keep0, 0, '0);
        do_cycle(1, AW'(12'h400), rnd_data(), 0, '0);
        do_cycle(0, '0, '0, 1, AW'(0));
        do_cycle(0, '0, '0, 1, AW'(19'h7FFFF));
        idle(LAT + 2);

        // Randomized mixed traffic.
        for (int i = 0; i < 400; i++) begin
            bit w;
            bit r;
            w = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) != 0);
            a = AW'($urandom_range(0, 31));
            b = AW'($urandom_range(0, 31));
            if ($urandom_range(0, 31) == 0) a = AW'($urandom_range(DEP, 19'h7FFFF));
            if ($urandom_range(0, 31) == 0) b = AW'($urandom_range(DEP, 19'h7FFFF));
            if (b < DEP && !wrtn[b[ML-1:0]]) r = 0;
            do_cycle(w, a, rnd_data(), r, b);
        end
        idle(LAT + 2);

        // Reset with reads in flight.
        for (int i = 0; i < 4; i++) do_cycle(0, '0, '0, 1, AW'(i));
        idle(1);
        do_reset();
        for (int i = 0; i < CAL + 4; i++) begin
            do_cycle($urandom_range(0, 1) == 1, AW'(1), rnd_data(),
                     $urandom_range(0, 1) == 1, AW'(1));
        end
        do_cycle(0, '0, '0, 1, AW'(1));

        for (int i = 0; i < 4 * LAT && sb.size() > 0; i++) idle(1);
        idle(1);
        check("scoreboard_drained", W'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
